// File: rtl/gamma_sched.sv
// Gamma sequencer: runs fixed-length gammas, applies buffered delay configurations
// only at gamma boundaries, and handles start/stop and datapath reset.
module gamma_sched #(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int N_UNITS           = 4,
  parameter int INIT_CYCLES       = 2,
  localparam int DW               = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  grst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  cfg_valid,
  input  logic [N_UNITS*DW-1:0] cfg_delay,
  output logic                  cfg_ready,
  output logic [N_UNITS*DW-1:0] delay_out,
  output logic [DW-1:0]         phase,
  output logic                  gamma_start,
  output logic                  unit_rst,
  output logic                  running,
  output logic                  cfg_applied,
  output logic [15:0]           gamma_count
);

  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         phase_q, phase_d;
  logic [N_UNITS*DW-1:0] delay_q, delay_d;
  logic [N_UNITS*DW-1:0] pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [15:0]           gcount_q, gcount_d;
  logic                  gstart_q, gstart_d;
  logic                  applied_q, applied_d;
  logic                  running_q, running_d;
  logic                  urst_q, urst_d;
  logic [ICW-1:0]        init_cnt_q, init_cnt_d;
  logic                  enter_gamma;
  logic                  last_phase;

  assign cfg_ready   = !pend_valid_q && !grst;
  assign delay_out   = delay_q;
  assign phase       = phase_q;
  assign gamma_start = gstart_q;
  assign unit_rst    = urst_q;
  assign running     = running_q;
  assign cfg_applied = applied_q;
  assign gamma_count = gcount_q;

  // G is a power of two, so the last phase is all ones.
  assign last_phase = &phase_q;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    delay_d      = delay_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    gcount_d     = gcount_q;
    gstart_d     = 1'b0;
    applied_d    = 1'b0;
    running_d    = running_q;
    urst_d       = urst_q;
    init_cnt_d   = init_cnt_q;
    enter_gamma  = 1'b0;

    if (cfg_valid && cfg_ready) begin
      pend_d       = cfg_delay;
      pend_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        phase_d   = '0;
        urst_d    = 1'b1;
        running_d = 1'b0;
        if (start && !stop) begin
          state_d    = S_INIT;
          init_cnt_d = '0;
        end
      end
      S_INIT: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (init_cnt_q == ICW'(INIT_CYCLES - 1)) begin
          state_d     = S_RUN;
          enter_gamma = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + ICW'(1);
        end
      end
      S_RUN: begin
        phase_d = phase_q + DW'(1);
        if (last_phase) begin
          gcount_d    = gcount_q + 16'd1;
          enter_gamma = 1'b1;
        end
        if (stop) state_d = S_STOPPING;
      end
      S_STOPPING: begin
        phase_d = phase_q + DW'(1);
        if (last_phase) begin
          gcount_d  = gcount_q + 16'd1;
          state_d   = S_IDLE;
          urst_d    = 1'b1;
          running_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Apply uses pend_valid_q, so a config accepted on this same edge waits a gamma.
    if (enter_gamma) begin
      phase_d   = '0;
      gstart_d  = 1'b1;
      urst_d    = 1'b0;
      running_d = 1'b1;
      if (pend_valid_q) begin
        delay_d      = pend_q;
        pend_valid_d = 1'b0;
        applied_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (grst) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      delay_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      gcount_q     <= '0;
      gstart_q     <= 1'b0;
      applied_q    <= 1'b0;
      running_q    <= 1'b0;
      urst_q       <= 1'b1;
      init_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      delay_q      <= delay_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      gcount_q     <= gcount_d;
      gstart_q     <= gstart_d;
      applied_q    <= applied_d;
      running_q    <= running_d;
      urst_q       <= urst_d;
      init_cnt_q   <= init_cnt_d;
    end
  end

endmodule

// File: doc/gamma_sched.md
GAMMA_SCHED -- requirements
Module: gamma_sched

Interface
REQ-001 SHALL have parameter GAMMA_CYCLE_WIDTH, default 16, giving gamma length G in aclk cycles; it is a power of 2 and at least 4.
REQ-002 SHALL have parameter N_UNITS, default 4, giving the number of delay units scheduled.
REQ-003 SHALL have parameter INIT_CYCLES, default 2, giving the number of cycles the datapath is held in reset before running.
REQ-004 SHALL derive DW = $clog2(GAMMA_CYCLE_WIDTH) as the delay and phase width.
REQ-005 SHALL have port aclk, input, 1 bit: clock, all logic on the rising edge.
REQ-006 SHALL have port grst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1 bit: begin gamma sequencing; honoured in IDLE only.
REQ-008 SHALL have port stop, input, 1 bit: request to halt at the end of the current gamma.
REQ-009 SHALL have port cfg_valid, input, 1 bit: a delay configuration is offered.
REQ-010 SHALL have port cfg_delay, input, N_UNITS*DW bits: per-unit delays; unit k uses bits [k*DW +: DW].
REQ-011 SHALL have port cfg_ready, output, 1 bit: the one-entry pending buffer is empty.
REQ-012 SHALL have port delay_out, output, N_UNITS*DW bits: active delays, constant for a whole gamma.
REQ-013 SHALL have port phase, output, DW bits: cycle index within the current gamma.
REQ-014 SHALL have port gamma_start, output, 1 bit: high on phase 0 of every running gamma; drives the datapath gamma restart.
REQ-015 SHALL have port unit_rst, output, 1 bit: datapath reset.
REQ-016 SHALL have port running, output, 1 bit: high in RUN and STOPPING.
REQ-017 SHALL have port cfg_applied, output, 1 bit: one-cycle pulse in the phase-0 cycle in which delay_out took a new value.
REQ-018 SHALL have port gamma_count, output, 16 bits: completed gammas, wrapping modulo 2^16.

Function
REQ-019 SHALL implement the states IDLE, INIT, RUN and STOPPING; all outputs are registered except cfg_ready, which equals !pending_valid && !grst.
REQ-020 SHALL, in IDLE, hold unit_rst=1, gamma_start=0 and phase=0; start=1 with stop=0 goes to INIT, and start with stop together stays in IDLE.
REQ-021 SHALL, in INIT, hold unit_rst=1 for exactly INIT_CYCLES cycles and then enter RUN; stop seen during INIT returns to IDLE on the next cycle.
REQ-022 SHALL, in the first RUN cycle, have phase=0, gamma_start=1 and unit_rst=0.
REQ-023 SHALL increment phase by 1 per cycle in RUN and STOPPING, wrapping G-1 to 0.
REQ-024 SHALL, at each wrap, increment gamma_count by 1 and assert gamma_start in the new phase-0 cycle.
REQ-025 SHALL accept a configuration on the handshake cfg_valid && cfg_ready by writing the pending register and setting pending_valid; it never overwrites a full buffer.
REQ-026 SHALL update delay_out only on entry to phase 0 (INIT to RUN, or a wrap), from the pending register if pending_valid was set before that edge.
REQ-027 SHALL, on that update, clear pending_valid and pulse cfg_applied; a configuration accepted in the phase G-1 cycle applies at the following boundary, not the immediate one.
REQ-028 SHALL never change delay_out mid-gamma.
REQ-029 SHALL, on stop in RUN, go to STOPPING; stop is sticky, and later stops have no further effect.
REQ-030 SHALL, in STOPPING, finish the current gamma; at phase G-1 it counts the gamma, enters IDLE with phase=0, does not pulse gamma_start and does not apply pending.
REQ-031 SHALL retain pending contents across IDLE, so they apply at the next start.
REQ-032 SHALL ignore start outside IDLE.

Reset
REQ-033 SHALL, while grst=1, force state IDLE, phase=0, delay_out=0, pending_valid=0, gamma_count=0, gamma_start=0, cfg_applied=0, running=0, unit_rst=1 and cfg_ready=0.
REQ-034 SHALL, on grst mid-gamma, discard the gamma in progress and the pending configuration, with no gamma_count increment; the first post-reset cycle shows cfg_ready=1.

Verification (G=16, N_UNITS=4, INIT_CYCLES=2)
REQ-035 SHALL cover: grst, then cfg 0x3A15 in IDLE, then start -> unit_rst high 2 cycles; next cycle phase=0, gamma_start=1, delay_out=0x3A15, cfg_applied=1.
REQ-036 SHALL cover: RUN for 40 cycles -> gamma_start high exactly at cycles 0, 16 and 32; gamma_count=2; phase=7 at cycle 39.
REQ-037 SHALL cover: cfg 0x1111 accepted at phase 5, cfg_valid held with 0x2222 -> cfg_ready=0 until the boundary; delay_out=0x1111 at the next phase 0; 0x2222 accepted that cycle and applied one gamma later.
REQ-038 SHALL cover: cfg 0x4444 accepted at phase 15 -> delay_out unchanged at the immediate phase 0; 0x4444 at the next phase 0.
REQ-039 SHALL cover: stop at phase 3 -> running stays 1 through phase 15; then IDLE, unit_rst=1, no extra gamma_start, gamma_count +1.
REQ-040 SHALL cover: grst at phase 9 with pending full -> all reset values next cycle, gamma_count=0, pending lost, cfg_ready=1 after release.
